// File: rtl/apb4_master_bridge_if.sv
// Purpose: bundles the request/response handshake and APB4 bus of the bridge.
// Latency: none; wiring only.
// Backpressure: carries req_ready_o / rsp_ready_i; no buffering of its own.
interface apb4_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Command port
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [STRB_WIDTH-1:0] req_wstrb_i;

  // Response port
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  // APB4 bus
  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  // Bridge side
  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  // Requester / APB peripheral side
  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb4_master_bridge.sv
// Purpose: APB4 initiator turning single valid/ready requests into SETUP/ACCESS transfers.
// Latency: handshake -> rsp_valid_o in 3 cycles plus one per wait state; one transfer per 4 cycles.
// Backpressure: req_ready_o only in IDLE; response held until rsp_ready_i; ACCESS aborted after TIMEOUT waits.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,   // multiple of 8
  parameter int TIMEOUT    = 256   // 0 disables the wait-state timeout
) (
  input logic                 pclk,
  input logic                 presetn,
  apb4_master_bridge_if.master bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CW         = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  // Counter value seen on the last ACCESS cycle allowed before abort
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         wait_cnt_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  // Transfer sequencer: latches the request, walks SETUP/ACCESS, holds the response
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            paddr_q   <= bus.req_addr_i;
            pwrite_q  <= bus.req_write_i;
            pwdata_q  <= bus.req_wdata_i;
            // Reads never drive strobes
            pstrb_q   <= bus.req_write_i ? bus.req_wstrb_i : '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.pready) begin
            // pready wins even on the cycle the timeout would fire
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q     <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
            state_q       <= ST_RESP;
          end else if ((TIMEOUT != 0) && (wait_cnt_q == TO_LAST)) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= ST_RESP;
          end else if (wait_cnt_q != CNT_MAX) begin
            // Saturates so a disabled timeout cannot wrap the counter
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o   = (state_q == ST_IDLE);
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;
  assign bus.paddr         = paddr_q;
  assign bus.pprot         = 3'b000;
  assign bus.psel          = psel_q;
  assign bus.penable       = penable_q;
  assign bus.pwrite        = pwrite_q;
  assign bus.pwdata        = pwdata_q;
  assign bus.pstrb         = pstrb_q;

endmodule
